// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arb_pkg
//  Description : Shared state encoding and requester indices for the 2:1
//                mux arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage : mux_arb_pkg
`default_nettype wire

// File: rtl/mux_2x1.sv
`default_nettype none
// ============================================================================
//  Module      : mux_2x1
//  Description : Single-bit 2:1 multiplexer; sel=0 picks a[0], sel=1 a[1].
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_2x1 (
    input  logic [1:0] a,
    input  logic       sel,
    output logic       y
);

    assign y = a[sel];

endmodule : mux_2x1
`default_nettype wire

// File: rtl/mux_arbiter_2x1.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arbiter_2x1
//  Description : Round-robin arbiter with hold limit sharing one 2:1 mux
//                datapath between two requesters.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_arbiter_2x1
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [1:0]       gnt,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             valid
);

    localparam int CNT_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    localparam logic             c_hold_en   = (MAX_HOLD > 0);
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_LAST);
    localparam logic [CNT_W-1:0] c_hold_max  = CNT_W'(MAX_HOLD);

    arb_state_t       r_state_q, w_state_d;
    arb_state_t       w_other_st;
    logic             r_last_q, w_last_d;
    logic             r_sel_q, w_sel_d;
    logic [CNT_W-1:0] r_cnt_q, w_cnt_d;
    logic             w_own, w_other, w_hold_fire;

    always_comb begin
        w_state_d   = r_state_q;
        w_last_d    = r_last_q;
        w_sel_d     = r_sel_q;
        w_cnt_d     = '0;
        w_own       = 1'b0;
        w_other     = 1'b0;
        w_other_st  = IDLE;
        w_hold_fire = 1'b0;

        unique case (r_state_q)
            GNT0: begin
                w_own      = req[REQ0];
                w_other    = req[REQ1];
                w_other_st = GNT1;
            end
            GNT1: begin
                w_own      = req[REQ1];
                w_other    = req[REQ0];
                w_other_st = GNT0;
            end
            default: ;
        endcase

        if (r_state_q == IDLE) begin
            // On a tie the requester opposite to the last winner goes first
            if (req[REQ0] && req[REQ1]) begin
                w_state_d = (r_last_q == REQ1) ? GNT0 : GNT1;
            end else if (req[REQ0]) begin
                w_state_d = GNT0;
            end else if (req[REQ1]) begin
                w_state_d = GNT1;
            end
        end else begin
            w_hold_fire = c_hold_en && w_other && (r_cnt_q == c_hold_last);
            if (w_hold_fire || (!w_own && w_other)) begin
                w_state_d = w_other_st;
            end else if (!w_own) begin
                w_state_d = IDLE;
            end else if (w_other) begin
                w_cnt_d = (c_hold_en && (r_cnt_q != c_hold_max)) ? r_cnt_q + 1'b1 : r_cnt_q;
            end
        end

        // sel and last track whichever grant is being entered; IDLE keeps them
        if (w_state_d == GNT0) begin
            w_last_d = REQ0;
            w_sel_d  = REQ0;
        end else if (w_state_d == GNT1) begin
            w_last_d = REQ1;
            w_sel_d  = REQ1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_last_q  <= REQ1;
            r_sel_q   <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_last_q  <= w_last_d;
            r_sel_q   <= w_sel_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign gnt   = {(r_state_q == GNT1), (r_state_q == GNT0)};
    assign valid = |gnt;
    assign sel   = r_sel_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux_2x1 u_mux (
            .a   ({d1[i], d0[i]}),
            .sel (r_sel_q),
            .y   (y[i])
        );
    end

endmodule : mux_arbiter_2x1
`default_nettype wire

// File: tb/tb_mux_arbiter_2x1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_arbiter_2x1
//  Description : Directed self-checking bench for mux_arbiter_2x1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_arbiter_2x1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [3:0] d0, d1;
    logic [1:0] gnt, gnt_h0;
    logic       sel, sel_h0, valid, valid_h0;
    logic [3:0] y;
    logic       y_h0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_arbiter_2x1 #(.WIDTH(4), .MAX_HOLD(4)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .d0    (d0),
        .d1    (d1),
        .gnt   (gnt),
        .sel   (sel),
        .y     (y),
        .valid (valid)
    );

    mux_arbiter_2x1 #(.WIDTH(1), .MAX_HOLD(0)) u_dut_h0 (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .d0    (d0[0]),
        .d1    (d1[0]),
        .gnt   (gnt_h0),
        .sel   (sel_h0),
        .y     (y_h0),
        .valid (valid_h0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_gnt;
        logic [1:0] winners [3];
        winners[0] = 2'b01;
        winners[1] = 2'b10;
        winners[2] = 2'b01;

        // Reset with both requesting
        rst = 1'b1; req = 2'b11; d0 = 4'h5; d1 = 4'hA;
        tick(); tick();
        check("rst_gnt",    gnt,      2'b00);
        check("rst_valid",  valid,    1'b0);
        check("rst_sel",    sel,      1'b0);
        check("rst_y",      y,        4'h5);
        check("rst_gnt_h0", gnt_h0,   2'b00);

        rst = 1'b0;
        tick();
        check("tie_gnt",    gnt,      2'b01);
        check("tie_sel",    sel,      1'b0);
        check("tie_y",      y,        4'h5);
        check("tie_valid",  valid,    1'b1);
        check("tie_gnt_h0", gnt_h0,   2'b01);

        // Hold limit 4 alternates every 4 grants; limit 0 never rotates
        for (int i = 1; i < 12; i++) begin
            tick();
            exp_gnt = (((i / 4) % 2) == 0) ? 2'b01 : 2'b10;
            check("hold_gnt",   gnt,    exp_gnt);
            check("hold_y",     y,      (exp_gnt == 2'b10) ? 4'hA : 4'h5);
            check("hold0_gnt",  gnt_h0, 2'b01);
        end

        // Handover without an idle bubble
        req = 2'b10;
        tick();
        check("ho_gnt",     gnt,      2'b10);
        check("ho_sel",     sel,      1'b1);
        check("ho_y",       y,        4'hA);
        check("ho_gnt_h0",  gnt_h0,   2'b10);
        check("ho_y_h0",    y_h0,     1'b0);
        check("ho_vld_h0",  valid_h0, 1'b1);

        req = 2'b00;
        tick();
        check("drop_gnt",   gnt,      2'b00);
        check("drop_sel",   sel,      1'b1);
        check("drop_valid", valid,    1'b0);
        check("drop_sel_h0", sel_h0,  1'b1);
        d1 = 4'h3;
        #1;
        check("idle_y",     y,        4'h3);

        // Single requester from IDLE
        req = 2'b10;
        tick();
        check("single_gnt", gnt,      2'b10);
        check("single_y",   y,        4'h3);
        req = 2'b00;
        tick();
        check("single_drop", gnt,     2'b00);

        // Round-robin on repeated ties
        for (int k = 0; k < 3; k++) begin
            req = 2'b11;
            tick();
            check("rr_gnt",  gnt, winners[k]);
            req = 2'b00;
            tick();
            check("rr_idle", gnt, 2'b00);
        end

        // Reset while in GNT1 with cnt=2
        req = 2'b11;
        tick();
        check("mid_gnt1",   gnt,      2'b10);
        tick(); tick();
        check("mid_gnt1b",  gnt,      2'b10);
        rst = 1'b1;
        tick();
        check("mid_rst_gnt", gnt,     2'b00);
        check("mid_rst_sel", sel,     1'b0);
        check("mid_rst_vld", valid,   1'b0);
        rst = 1'b0;
        tick();
        check("mid_rel_gnt", gnt,     2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux_arbiter_2x1
`default_nettype wire
